mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one N-to-1 multiplexer datapath among N requesters. Each requester raises a request line and owns the mux until it drops the request. The block drives the mux selector, a one-hot grant vector and a busy flag. It sits directly in front of the multiplexer bank as its select controller.

## Interface
- N, default 4: number of requesters (2..16).
- SELW, default $clog2(N): selector width; derived, do not override.
- MAX_HOLD, default 16: maximum grant length in cycles when timeout is compiled in (2..255).

- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request per requester; requester i holds req[i] high for as long as it needs the mux.
- grant  output  N  one-hot grant, registered; all zeros when idle.
- sel  output  SELW  binary index of the current owner, registered; drives the mux select.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked; constant 0 without ARB_TIMEOUT_EN.

## Operation
- Two states: IDLE and OWNED. Internal round-robin pointer ptr (SELW bits) and owner register.
- Reset values:
  - state=IDLE, ptr=0, grant=0, sel=0, busy=0, timeout=0, hold counter=0.
- IDLE:
  - If req≠0, choose the first set bit at index ptr, ptr+1, … wrapping modulo N.
  - Next state OWNED, grant=one-hot(owner), sel=owner, busy=1.
  - ptr=(owner+1) mod N, wrapping from N-1 to 0.
  - If req=0, stay in IDLE; outputs stay at their idle values, and sel holds its last value.
- OWNED:
  - While req[owner]=1, stay in OWNED; outputs are stable and requests from others are ignored.
  - When req[owner]=0 is sampled, go to IDLE with grant=0 and busy=0 on the next edge.
  - Every handover therefore includes exactly one idle cycle, so the mux never switches while a grant is asserted.
- sel changes only on the edge that asserts a new grant, never while busy=1.
- grant is always one-hot or zero.
- Simultaneous requests are resolved by ptr order only; request arrival time does not matter.
- A requester that drops and re-raises req in the same cycle its grant ends is arbitrated normally. It has lowest priority because ptr has moved past it.
- rst has priority over all other inputs. Asserted mid-grant, it forces the reset values on the next edge regardless of req.

## Timing
- Grant latency from IDLE: req sampled high at edge k → grant, sel and busy valid after edge k.
- Release: req[owner] sampled low at edge k → grant=0 after edge k.
- Next grant no earlier than edge k+1.
- Minimum ownership is 1 cycle; minimum handover gap is 1 idle cycle.
- All outputs are registered; there are no combinational paths from req to any output.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A hold counter resets to 0 on each grant and increments every OWNED cycle.
  - If the counter reaches MAX_HOLD-1 while req[owner] is still 1, the block returns to IDLE on the next edge with grant=0 and timeout=1 for that one cycle.
  - ptr has already passed the revoked owner, so it is re-served only after the others.
- ARB_TIMEOUT_EN undefined: no counter is built, ownership is unbounded, and timeout is tied to 0.

## Structure
- Shared package mux_arb_pkg holds:
  - the state enumeration (ARB_IDLE, ARB_OWNED);
  - the default constants ARB_N_DEF=4 and ARB_MAX_HOLD_DEF=16.
- One sub-module: rr_pick, a purely combinational function of req and ptr that returns found and idx (the first set request at or after ptr, with wrap).
- The top level holds the state register, ptr, outputs and the optional counter.

## Test plan
- Reset:
  - Stimulus: rst high 2 cycles, with req=4'b1111 held throughout.
  - Required response: grant=0, sel=0, busy=0 during reset. After release, first grant=4'b0001, sel=0, ptr=1.
- Round-robin:
  - Stimulus: req=4'b1111 constant, and each owner drops its req for 1 cycle after 3 cycles of ownership.
  - Required response: grant order 0001, 0010, 0100, 1000, 0001, with exactly one grant=0 cycle between owners.
- Wrap and skip:
  - Stimulus: ptr=3 (after serving requester 2), then req=4'b0011.
  - Required response: grant=4'b0001 and sel=0, because requester 3 is idle and the search wraps.
- Hold and ignore:
  - Stimulus: requester 1 owns the mux; req[3] rises mid-grant; req[1] stays high 10 cycles.
  - Required response: grant=4'b0010 and sel=1 stable all 10 cycles, then grant=4'b1000 two edges after req[1] falls.
- Mid-grant reset:
  - Stimulus: rst pulses while grant=4'b0100.
  - Required response: next edge gives grant=0, busy=0, sel=0; re-arbitration then starts from ptr=0.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4):
  - Stimulus: req=4'b0101 held high.
  - Required response: grant=0001 for 4 cycles, then one cycle of grant=0 with timeout=1, then grant=0100.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin mux arbiter:
//   arb_state_e       - arbiter FSM states (ARB_IDLE, ARB_OWNED)
//   ARB_N_DEF         - default number of requesters
//   ARB_MAX_HOLD_DEF  - default maximum grant length (used with ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 16;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin search: returns the first set request at
// index ptr, ptr+1, ... wrapping modulo N.
// Ports:
//   req   [N-1:0]     request vector
//   ptr   [SELW-1:0]  search start index (0..N-1)
//   found             at least one request is set
//   idx   [SELW-1:0]  index of the selected request (0 when found=0)
// -----------------------------------------------------------------------------
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N    = ARB_N_DEF,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  localparam logic [SELW:0] N_W = (SELW + 1)'(N);

  logic [SELW:0] cand;

  // Walk offsets from the far end back to 0 so the closest set request
  // to ptr is the one that lands last; no early exit is needed.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (SELW + 1)'(i);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (req[cand[SELW-1:0]]) begin
        found = 1'b1;
        idx   = cand[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin select controller for an N-to-1 multiplexer bank. A requester
// owns the mux for as long as it holds its request; every handover passes
// through one idle cycle so the mux select never moves under an active grant.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req   [N-1:0]  request per requester
//   grant [N-1:0]  registered one-hot grant, zero when idle
//   sel   [SELW-1:0] registered binary owner index (mux select)
//   busy           high while a grant is active
//   timeout        one-cycle pulse when a grant is revoked
// Build option: define ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles;
// without it no hold counter exists and timeout is constant 0.
// -----------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int SELW     = $clog2(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            timeout
);

  arb_state_e      state_q;
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;
  logic [SELW-1:0] sel_q;      // doubles as the owner register
  logic [N-1:0]    grant_q;
  logic [N-1:0]    grant_d;
  logic            busy_q;

  logic            pick_found;
  logic [SELW-1:0] pick_idx;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
  assign ptr_d   = (pick_idx == SELW'(N - 1)) ? '0 : pick_idx + SELW'(1);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       timeout_q;
`else
  localparam int unused_max_hold = MAX_HOLD;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ARB_IDLE: begin
          // sel is left alone when nothing is requested.
          if (pick_found) begin
            state_q <= ARB_OWNED;
            grant_q <= grant_d;
            sel_q   <= pick_idx;
            busy_q  <= 1'b1;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end
        end
        ARB_OWNED: begin
          // Only the owner's request matters here; others wait for IDLE.
          if (!req[sel_q]) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_q == 8'(MAX_HOLD - 1)) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed self-checking bench for mux_rr_arbiter (N=4, MAX_HOLD=4).
// Outputs are checked 1 time unit after each rising edge; inputs are changed
// at the same point so the next edge samples them.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int N    = 4;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [SELW-1:0] sel;
  logic            busy;
  logic            timeout;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    chk({tag, ".grant"},   32'(grant),   32'(g));
    chk({tag, ".sel"},     32'(sel),     32'(s));
    chk({tag, ".busy"},    32'(busy),    32'(b));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    logic [3:0] g_exp;

    // Reset held two cycles with every request up.
    rst = 1'b1;
    req = 4'b1111;
    step();
    chk_out("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Round-robin: each owner holds 3 cycles, drops req for one cycle.
    for (int k = 0; k < 5; k++) begin
      g_exp = 4'b0001 << (k % 4);
      chk_out($sformatf("rr%0d.c1", k), g_exp, 2'(k % 4), 1'b1, 1'b0);
      step();
      chk_out($sformatf("rr%0d.c2", k), g_exp, 2'(k % 4), 1'b1, 1'b0);
      step();
      chk_out($sformatf("rr%0d.c3", k), g_exp, 2'(k % 4), 1'b1, 1'b0);
      req = 4'b1111 & ~g_exp;
      step();
      chk_out($sformatf("rr%0d.gap", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      req = 4'b1111;
      if (k < 4) step();
    end

    // No requests: stay idle, sel holds the last owner (0).
    req = 4'b0000;
    step();
    chk_out("idle_hold", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Serve requester 2 so ptr becomes 3, then wrap-and-skip with 0011.
    req = 4'b0100;
    step();
    chk_out("serve2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_out("release2", 4'b0000, 2'd2, 1'b0, 1'b0);
    req = 4'b0011;
    step();
    chk_out("wrap_skip", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Hold and ignore: requester 1 owns, requester 3 arrives mid-grant.
    req = 4'b0010;
    step();
    chk_out("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      step();
      chk_out($sformatf("hold%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = 4'b1000;
    step();
    chk_out("hold_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    step();
    chk_out("own3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Mid-grant reset while requester 2 owns (ptr is 3 afterwards).
    req = 4'b0100;
    step();
    chk_out("rel3", 4'b0000, 2'd3, 1'b0, 1'b0);
    step();
    chk_out("own2", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Timeout scenario: reset to ptr=0, hold req=0101.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0101;
    step();
    chk_out("to_c0", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < 4; c++) begin
      step();
      chk_out($sformatf("to_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    chk_out("to_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_out("to_next", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
    for (int c = 1; c < 8; c++) begin
      step();
      chk_out($sformatf("unbounded%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
